hart_mem_arbiter: RTL and testbench

Sits directly downstream of the hart's instruction-fetch port and data-memory port. It merges both into one single-port memory bus. Requests are serialised with round-robin priority, and each transaction is held until the memory acknowledges it. A watchdog bounds how long a grant can stall, so a hung slave cannot lock up the hart.

---
 rtl/arvi_bus_pkg.sv | 22 ++
 rtl/arb_watchdog.sv | 39 +++
 rtl/hart_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared bus types for the hart-side memory arbiter (and the future D-cache).
// mem_req_t is sized for the widest supported bus; narrower XLEN uses the low bits.
package arvi_bus_pkg;

  localparam int BUS_XLEN = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                we;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wdata;
    logic [3:0]          be;
  } mem_req_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating stall counter: cleared on every grant, counts while enabled.
// o_expired is high in the cycle whose edge would bring the count to LIMIT.
module arb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // LIMIT of zero disables the watchdog entirely.
  assign o_expired = (LIMIT != 0) && i_en && (cnt_q >= (LIMIT_W - 1'b1));

endmodule

// File: rtl/hart_mem_arbiter.sv
// Merges the hart's fetch and data ports onto one single-port memory bus.
// Round-robin between requesters; each grant is held until ack or watchdog expiry.
module hart_mem_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter bit I_FIRST = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IM_Addr,
  output logic            o_IC_MemReady,
  output logic [XLEN-1:0] o_IM_Instr,
  input  logic            i_DM_req,
  input  logic            i_DM_we,
  input  logic [XLEN-1:0] i_DM_addr,
  input  logic [XLEN-1:0] i_DM_wdata,
  input  logic [3:0]      i_DM_be,
  output logic            o_DM_ready,
  output logic [XLEN-1:0] o_DM_rdata,
  output logic            o_bus_err,
  output logic            o_MEM_req,
  output logic            o_MEM_we,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wdata,
  output logic [3:0]      o_MEM_be,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ack,
  output logic [1:0]      o_dbg_state
);

  // Handshake: o_MEM_req stays high with stable addr/we/wdata/be until the
  // cycle i_MEM_ack is sampled high; a ready pulse then lasts exactly one cycle.

  arb_state_t      state_q, state_d;
  logic            prio_i_q, prio_i_d;
  mem_req_t        req_q, req_d;
  logic            mem_req_q, mem_req_d;
  logic            ic_ready_q, ic_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic            bus_err_q, bus_err_d;
  logic [XLEN-1:0] im_instr_q, im_instr_d;
  logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;

  logic grant_i;
  logic grant_d;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign wd_en = (state_q == BUSY_I) || (state_q == BUSY_D);

  arb_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (wd_clr),
    .i_en     (wd_en),
    .o_expired(wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    prio_i_d   = prio_i_q;
    req_d      = req_q;
    mem_req_d  = mem_req_q;
    ic_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    bus_err_d  = 1'b0;
    im_instr_d = im_instr_q;
    dm_rdata_d = dm_rdata_q;
    wd_clr     = 1'b0;
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      IDLE: begin
        grant_i = i_IC_DataReq && (!i_DM_req || prio_i_q);
        grant_d = i_DM_req && !grant_i;
        // Any grant points priority at the other side for the next contest.
        if (grant_i) begin
          state_d     = BUSY_I;
          prio_i_d    = 1'b0;
          req_d.we    = 1'b0;
          req_d.addr  = BUS_XLEN'(i_IM_Addr);
          req_d.wdata = '0;
          req_d.be    = BE_ALL;
          mem_req_d   = 1'b1;
          wd_clr      = 1'b1;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          prio_i_d    = 1'b1;
          req_d.we    = i_DM_we;
          req_d.addr  = BUS_XLEN'(i_DM_addr);
          req_d.wdata = BUS_XLEN'(i_DM_wdata);
          req_d.be    = i_DM_be;
          mem_req_d   = 1'b1;
          wd_clr      = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack in the expiry cycle still completes normally.
        if (i_MEM_ack || wd_expired) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = !i_MEM_ack;
          if (state_q == BUSY_I) begin
            ic_ready_d = 1'b1;
            im_instr_d = i_MEM_ack ? i_MEM_rdata : '0;
          end else begin
            dm_ready_d = 1'b1;
            if (!i_MEM_ack) begin
              dm_rdata_d = '0;
            end else if (!req_q.we) begin
              dm_rdata_d = i_MEM_rdata;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      prio_i_q   <= I_FIRST;
      req_q      <= '0;
      mem_req_q  <= 1'b0;
      ic_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      im_instr_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_i_q   <= prio_i_d;
      req_q      <= req_d;
      mem_req_q  <= mem_req_d;
      ic_ready_q <= ic_ready_d;
      dm_ready_q <= dm_ready_d;
      bus_err_q  <= bus_err_d;
      im_instr_q <= im_instr_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign o_MEM_req     = mem_req_q;
  assign o_MEM_we      = req_q.we;
  assign o_MEM_addr    = req_q.addr[XLEN-1:0];
  assign o_MEM_wdata   = req_q.wdata[XLEN-1:0];
  assign o_MEM_be      = req_q.be;
  assign o_IC_MemReady = ic_ready_q;
  assign o_DM_ready    = dm_ready_q;
  assign o_bus_err     = bus_err_q;
  assign o_IM_Instr    = im_instr_q;
  assign o_DM_rdata    = dm_rdata_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed bench for hart_mem_arbiter: vector table of single transactions plus
// hand-written sequences for priority, back-to-back, reset and watchdog cases.
module tb_hart_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, b_rst;
  logic        ic_req, dm_req, dm_we, mem_ack;
  logic [31:0] im_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;

  logic        a_ic_ready, a_dm_ready, a_bus_err, a_mem_req, a_mem_we;
  logic [31:0] a_im_instr, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [1:0]  a_state;

  logic        b_ic_req, b_dm_req, b_mem_ack;
  logic [31:0] b_dm_addr, b_mem_rdata;
  logic        b_ic_ready, b_dm_ready, b_bus_err, b_mem_req, b_mem_we;
  logic [31:0] b_im_instr, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_state;

  hart_mem_arbiter #(.XLEN(32), .TIMEOUT(255), .I_FIRST(1'b1)) dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .i_IC_DataReq(ic_req), .i_IM_Addr(im_addr),
    .o_IC_MemReady(a_ic_ready), .o_IM_Instr(a_im_instr),
    .i_DM_req(dm_req), .i_DM_we(dm_we), .i_DM_addr(dm_addr),
    .i_DM_wdata(dm_wdata), .i_DM_be(dm_be),
    .o_DM_ready(a_dm_ready), .o_DM_rdata(a_dm_rdata), .o_bus_err(a_bus_err),
    .o_MEM_req(a_mem_req), .o_MEM_we(a_mem_we), .o_MEM_addr(a_mem_addr),
    .o_MEM_wdata(a_mem_wdata), .o_MEM_be(a_mem_be),
    .i_MEM_rdata(mem_rdata), .i_MEM_ack(mem_ack), .o_dbg_state(a_state)
  );

  hart_mem_arbiter #(.XLEN(32), .TIMEOUT(4), .I_FIRST(1'b1)) dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_IC_DataReq(b_ic_req), .i_IM_Addr(im_addr),
    .o_IC_MemReady(b_ic_ready), .o_IM_Instr(b_im_instr),
    .i_DM_req(b_dm_req), .i_DM_we(dm_we), .i_DM_addr(b_dm_addr),
    .i_DM_wdata(dm_wdata), .i_DM_be(dm_be),
    .o_DM_ready(b_dm_ready), .o_DM_rdata(b_dm_rdata), .o_bus_err(b_bus_err),
    .o_MEM_req(b_mem_req), .o_MEM_we(b_mem_we), .o_MEM_addr(b_mem_addr),
    .o_MEM_wdata(b_mem_wdata), .o_MEM_be(b_mem_be),
    .i_MEM_rdata(b_mem_rdata), .i_MEM_ack(b_mem_ack), .o_dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_a_zero(input string name);
    check({name, " mem_req"},  32'(a_mem_req), 32'd0);
    check({name, " mem_we"},   32'(a_mem_we), 32'd0);
    check({name, " mem_addr"}, a_mem_addr, 32'd0);
    check({name, " mem_wdat"}, a_mem_wdata, 32'd0);
    check({name, " mem_be"},   32'(a_mem_be), 32'd0);
    check({name, " ic_rdy"},   32'(a_ic_ready), 32'd0);
    check({name, " dm_rdy"},   32'(a_dm_ready), 32'd0);
    check({name, " err"},      32'(a_bus_err), 32'd0);
    check({name, " instr"},    a_im_instr, 32'd0);
    check({name, " rdata"},    a_dm_rdata, 32'd0);
    check({name, " state"},    32'(a_state), 32'd0);
  endtask

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic wait_grant_a(input string name, output int lat);
    lat = 0;
    while (a_mem_req !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " req"}, 32'(a_mem_req), 32'd1);
    check({name, " addr"}, a_mem_addr, exp_q.pop_front());
  endtask

  task automatic mem_serve_a(input string name, input int delay,
                             input logic [31:0] addr, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({name, " hold req"}, 32'(a_mem_req), 32'd1);
      check({name, " hold addr"}, a_mem_addr, addr);
    end
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
  endtask

  task automatic check_resp_a(input string name, input logic ic, input logic dm,
                              input logic [31:0] instr, input logic [31:0] rdata);
    check({name, " ic_rdy"}, 32'(a_ic_ready), 32'(ic));
    check({name, " dm_rdy"}, 32'(a_dm_ready), 32'(dm));
    check({name, " err"},    32'(a_bus_err), 32'd0);
    check({name, " req off"}, 32'(a_mem_req), 32'd0);
    check({name, " instr"},  a_im_instr, instr);
    check({name, " rdata"},  a_dm_rdata, rdata);
  endtask

  task automatic wait_req_b(input string name);
    int n = 0;
    while (b_mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " req"}, 32'(b_mem_req), 32'd1);
    check({name, " addr"}, b_mem_addr, b_dm_addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_instr;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  localparam int NV = 5;
  vec_t vec[NV];

  initial begin
    vec_t v;
    int lat;
    logic [31:0] seq_rd[4];
    logic [31:0] seq_instr[4];
    int n;

    vec[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0000_0013, 1'b0, 4'hF, 32'h0000_0013, 32'h0};
    vec[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 7, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0000_0013, 32'hCAFE_F00D};
    vec[2] = '{1'b1, 1'b1, 32'h0000_8000, 32'hDEAD_BEEF, 4'h3, 0, 32'h1234_5678, 1'b1, 4'h3, 32'h0000_0013, 32'hCAFE_F00D};
    vec[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'h0050_0093, 1'b0, 4'hF, 32'h0050_0093, 32'hCAFE_F00D};
    vec[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h1, 1, 32'h0000_00AB, 1'b0, 4'h1, 32'h0050_0093, 32'h0000_00AB};

    a_rst = 1'b1; b_rst = 1'b1;
    ic_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    im_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; dm_be = '0;
    b_ic_req = 1'b0; b_dm_req = 1'b0; b_mem_ack = 1'b0; b_dm_addr = '0; b_mem_rdata = '0;
    repeat (3) @(negedge clk);

    check_a_zero("reset_a");
    check("reset_b outs", {b_mem_req, b_mem_we, b_ic_ready, b_dm_ready, b_bus_err, b_mem_be, b_state},
          32'd0);
    check("reset_b data", b_mem_addr | b_mem_wdata | b_im_instr | b_dm_rdata, 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Table: one transaction per record, started from IDLE.
    for (int k = 0; k < NV; k++) begin
      string nm;
      v  = vec[k];
      nm = $sformatf("vec%0d", k);
      if (v.is_d) begin
        dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
        ic_req = 1'b0; im_addr = $urandom;
      end else begin
        ic_req = 1'b1; im_addr = v.addr;
        dm_req = 1'b0; dm_we = 1'b1; dm_be = 4'h0; dm_addr = $urandom; dm_wdata = $urandom;
      end
      exp_q.push_back(v.addr);
      wait_grant_a(nm, lat);
      check({nm, " latency"}, 32'(lat), 32'd1);
      check({nm, " we"}, 32'(a_mem_we), 32'(v.exp_we));
      check({nm, " be"}, 32'(a_mem_be), 32'(v.exp_be));
      if (v.we) check({nm, " wdata"}, a_mem_wdata, v.wdata);
      // Requester inputs move after grant; the bus must not follow them.
      im_addr = ~v.addr; dm_addr = ~v.addr; dm_be = ~v.be; dm_we = ~v.we;
      mem_serve_a(nm, v.delay, v.addr, v.rdata);
      check_resp_a(nm, !v.is_d, v.is_d, v.exp_instr, v.exp_dm_rdata);
      ic_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      check({nm, " pulse end"}, 32'({a_ic_ready, a_dm_ready}), 32'd0);
    end

    // Contention after reset: I first, then alternate D, I, D with both held.
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    ic_req = 1'b1; im_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_8000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    seq_rd    = '{32'h0000_0111, 32'h0000_0999, 32'h0000_0222, 32'h0000_0999};
    seq_instr = '{32'h0000_0111, 32'h0000_0111, 32'h0000_0222, 32'h0000_0222};
    for (int g = 0; g < 4; g++) begin
      string nm;
      logic is_i;
      nm   = $sformatf("rr%0d", g);
      is_i = (g % 2 == 0);
      exp_q.push_back(is_i ? 32'h0000_0200 : 32'h0000_8000);
      wait_grant_a(nm, lat);
      check({nm, " we"}, 32'(a_mem_we), is_i ? 32'd0 : 32'd1);
      check({nm, " be"}, 32'(a_mem_be), is_i ? 32'hF : 32'h3);
      mem_serve_a(nm, 0, is_i ? 32'h0000_0200 : 32'h0000_8000, seq_rd[g]);
      check_resp_a(nm, is_i, !is_i, seq_instr[g], 32'd0);
    end
    ic_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back data reads with req held: one IDLE cycle between them.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; dm_be = 4'hF;
    exp_q.push_back(32'h0000_0300);
    exp_q.push_back(32'h0000_0300);
    wait_grant_a("b2b0", lat);
    mem_serve_a("b2b0", 0, 32'h0000_0300, 32'h1111_2222);
    check_resp_a("b2b0", 1'b0, 1'b1, 32'h0000_0222, 32'h1111_2222);
    @(negedge clk);
    check("b2b gap req", 32'(a_mem_req), 32'd0);
    check("b2b gap state", 32'(a_state), 32'd0);
    @(negedge clk);
    check("b2b regrant", 32'(a_mem_req), 32'd1);
    wait_grant_a("b2b1", lat);
    mem_serve_a("b2b1", 1, 32'h0000_0300, 32'h3333_4444);
    check_resp_a("b2b1", 1'b0, 1'b1, 32'h0000_0222, 32'h3333_4444);
    dm_req = 1'b0;
    @(negedge clk);

    // Reset while a fetch is outstanding, then a stray late ack.
    ic_req = 1'b1; im_addr = 32'h0000_0500;
    exp_q.push_back(32'h0000_0500);
    wait_grant_a("rst_mid", lat);
    check("rst_mid busy_i", 32'(a_state), 32'd1);
    a_rst = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    check_a_zero("rst_mid");
    a_rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late ack rdy", 32'({a_ic_ready, a_dm_ready, a_mem_req}), 32'd0);
    @(negedge clk);
    check("late ack rdy2", 32'({a_ic_ready, a_dm_ready, a_mem_req}), 32'd0);
    check("late ack instr", a_im_instr, 32'd0);

    // Watchdog (TIMEOUT=4): a good read, a timeout, then ack on the expiry cycle.
    dm_we = 1'b0; dm_be = 4'hF;
    b_dm_req = 1'b1; b_dm_addr = 32'h0000_0060;
    wait_req_b("wd_ok");
    b_mem_ack = 1'b1; b_mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    b_mem_ack = 1'b0;
    check("wd_ok rdy", 32'(b_dm_ready), 32'd1);
    check("wd_ok err", 32'(b_bus_err), 32'd0);
    check("wd_ok rdata", b_dm_rdata, 32'h5A5A_5A5A);
    b_dm_req = 1'b0;
    repeat (2) @(negedge clk);

    b_dm_req = 1'b1; b_dm_addr = 32'h0000_0064;
    wait_req_b("wd_to");
    n = 0;
    while (b_mem_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("wd_to busy cycles", 32'(n), 32'd4);
    check("wd_to rdy", 32'(b_dm_ready), 32'd1);
    check("wd_to err", 32'(b_bus_err), 32'd1);
    check("wd_to rdata", b_dm_rdata, 32'd0);
    b_dm_req = 1'b0;
    @(negedge clk);
    check("wd_to pulse end", 32'({b_dm_ready, b_bus_err}), 32'd0);
    @(negedge clk);

    b_dm_req = 1'b1; b_dm_addr = 32'h0000_0068;
    wait_req_b("wd_race");
    repeat (3) @(negedge clk);
    check("wd_race still req", 32'(b_mem_req), 32'd1);
    b_mem_ack = 1'b1; b_mem_rdata = 32'h600D_D00D;
    @(negedge clk);
    b_mem_ack = 1'b0;
    check("wd_race rdy", 32'(b_dm_ready), 32'd1);
    check("wd_race err", 32'(b_bus_err), 32'd0);
    check("wd_race rdata", b_dm_rdata, 32'h600D_D00D);
    b_dm_req = 1'b0;
    @(negedge clk);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: got running want done");
    $fatal(1, "time limit");
  end

endmodule
